// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the unified memory port
// that mem_arbiter multiplexes.
interface mem_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wstrb;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  logic              err;
  logic              busy;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_ready, mem_rdata,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output err, busy
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output mem_ready, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  err, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port unified memory: alternating
// priority on ties, one transaction in flight, timeout abort reported on err.
module mem_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          resetn,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t            state;
  logic              last_d;
  logic [15:0]       cnt;
  logic              pick_d;
  logic [ADDR_W-1:0] addr_sel;

  // On a tie the requester that did not own the port last time wins.
  assign pick_d   = bus.d_req && (!bus.i_req || !last_d);
  assign addr_sel = pick_d ? bus.d_addr : bus.i_addr;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state         <= IDLE;
      last_d        <= 1'b0;
      cnt           <= '0;
      bus.i_gnt     <= 1'b0;
      bus.i_rvalid  <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_gnt     <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.d_rdata   <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
      bus.err       <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.i_gnt    <= 1'b0;
      bus.d_gnt    <= 1'b0;
      bus.i_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      bus.err      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            bus.mem_req   <= 1'b1;
            bus.mem_addr  <= addr_sel;
            bus.mem_we    <= pick_d & bus.d_we;
            bus.mem_wstrb <= pick_d ? bus.d_wstrb : 4'b0000;
            if (pick_d) bus.mem_wdata <= bus.d_wdata;
            bus.i_gnt     <= !pick_d;
            bus.d_gnt     <= pick_d;
            bus.busy      <= 1'b1;
            last_d        <= pick_d;
            cnt           <= '0;
            state         <= pick_d ? BUSY_D : BUSY_I;
          end
        end
        default: begin
          if (bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= IDLE;
            if (state == BUSY_I) begin
              bus.i_rvalid <= 1'b1;
              bus.i_rdata  <= bus.mem_rdata;
            end else begin
              bus.d_rvalid <= 1'b1;
              // Store completions leave the last load data in place.
              if (!bus.mem_we) bus.d_rdata <= bus.mem_rdata;
            end
          end else if (cnt == CNT_LAST) begin
            bus.mem_req <= 1'b0;
            bus.busy    <= 1'b0;
            bus.err     <= 1'b1;
            state       <= IDLE;
            if (state == BUSY_I) begin
              bus.i_rvalid <= 1'b1;
              bus.i_rdata  <= '0;
            end else begin
              bus.d_rvalid <= 1'b1;
              bus.d_rdata  <= '0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized transactions
// scored against a transaction-level model of arbitration and completion.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 24;
  localparam int TO = 8;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   tests_run = 0;
  int   fails     = 0;

  bit          model_last_d;
  logic [31:0] model_i_rdata;
  logic [31:0] model_d_rdata;
  logic [31:0] model_wdata;
  logic [AW-1:0] model_addr;

  mem_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_wstrb = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
  endtask

  function automatic logic [AW+107:0] all_outs();
    return {bus.i_gnt, bus.i_rvalid, bus.i_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata,
            bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb,
            bus.err, bus.busy};
  endfunction

  task automatic test_reset();
    clear_inputs();
    #2 resetn = 1'b1;
    #1;
    tests_run++; if (all_outs() !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", all_outs()); end
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b0;
    tick();
    tests_run++; if ({bus.mem_req, bus.busy, bus.i_gnt, bus.d_gnt} !== 4'b0000) begin fails++; $display("FAIL reset_idle: got %b want 0000", {bus.mem_req, bus.busy, bus.i_gnt, bus.d_gnt}); end
    model_last_d = 1'b0; model_i_rdata = '0; model_d_rdata = '0; model_wdata = '0; model_addr = '0;
  endtask

  task automatic test_tie_alternation();
    bus.i_req = 1'b1; bus.i_addr = 24'h000400;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 24'h000300;
    tick();
    tests_run++; if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin fails++; $display("FAIL tie1_gnt: got i/d=%b want 01", {bus.i_gnt, bus.d_gnt}); end
    tests_run++; if (bus.mem_addr !== 24'h000300) begin fails++; $display("FAIL tie1_addr: got %h want 000300", bus.mem_addr); end
    bus.d_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11111111;
    tick();
    tests_run++; if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h11111111}) begin fails++; $display("FAIL tie1_done: got %b/%h want 1/11111111", bus.d_rvalid, bus.d_rdata); end
    bus.mem_ready = 1'b0;
    tick();
    tests_run++; if ({bus.i_gnt, bus.d_gnt} !== 2'b10) begin fails++; $display("FAIL tie2_gnt: got i/d=%b want 10", {bus.i_gnt, bus.d_gnt}); end
    tests_run++; if ({bus.mem_addr, bus.mem_we} !== {24'h000400, 1'b0}) begin fails++; $display("FAIL tie2_addr: got %h/%b want 000400/0", bus.mem_addr, bus.mem_we); end
    bus.i_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h22222222;
    tick();
    tests_run++; if ({bus.i_rvalid, bus.i_rdata} !== {1'b1, 32'h22222222}) begin fails++; $display("FAIL tie2_done: got %b/%h want 1/22222222", bus.i_rvalid, bus.i_rdata); end
    bus.mem_ready = 1'b0; bus.i_req = 1'b1; bus.d_req = 1'b1;
    tick();
    tests_run++; if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin fails++; $display("FAIL tie3_gnt: got i/d=%b want 01", {bus.i_gnt, bus.d_gnt}); end
    bus.d_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h33333333;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    tests_run++; if ({bus.i_gnt, bus.d_gnt} !== 2'b10) begin fails++; $display("FAIL tie4_gnt: got i/d=%b want 10", {bus.i_gnt, bus.d_gnt}); end
    bus.i_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h44444444;
    tick();
    bus.mem_ready = 1'b0;
    model_last_d = 1'b0; model_i_rdata = 32'h44444444; model_d_rdata = 32'h33333333;
    model_addr = 24'h000400;
  endtask

  task automatic test_single_fetch();
    bus.i_req = 1'b1; bus.i_addr = 24'h000100;
    tick();
    tests_run++; if ({bus.i_gnt, bus.d_gnt, bus.mem_req, bus.busy} !== 4'b1011) begin fails++; $display("FAIL fetch_gnt: got gnt_i/gnt_d/req/busy=%b want 1011", {bus.i_gnt, bus.d_gnt, bus.mem_req, bus.busy}); end
    tests_run++; if ({bus.mem_addr, bus.mem_we, bus.mem_wstrb} !== {24'h000100, 1'b0, 4'b0000}) begin fails++; $display("FAIL fetch_bus: got %h/%b/%b want 000100/0/0000", bus.mem_addr, bus.mem_we, bus.mem_wstrb); end
    bus.i_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00000513;
    tick();
    tests_run++; if ({bus.i_rvalid, bus.i_rdata, bus.busy, bus.mem_req, bus.err} !== {1'b1, 32'h00000513, 3'b000}) begin fails++; $display("FAIL fetch_done: got %b/%h busy=%b req=%b err=%b want 1/00000513/0/0/0", bus.i_rvalid, bus.i_rdata, bus.busy, bus.mem_req, bus.err); end
    bus.mem_ready = 1'b0;
    tick();
    tests_run++; if (bus.i_rvalid !== 1'b0) begin fails++; $display("FAIL fetch_pulse: got %b want 0", bus.i_rvalid); end
    model_i_rdata = 32'h00000513; model_addr = 24'h000100;
  endtask

  task automatic test_store();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 24'h000200;
    bus.d_wdata = 32'hDEADBEEF; bus.d_wstrb = 4'b0011; bus.mem_rdata = 32'hBAD0BAD0;
    tick();
    tests_run++; if (bus.d_gnt !== 1'b1) begin fails++; $display("FAIL store_gnt: got %b want 1", bus.d_gnt); end
    bus.d_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.d_rvalid} !== {2'b11, 24'h000200, 32'hDEADBEEF, 4'b0011, 1'b0}) begin
        fails++; $display("FAIL store_bus_c%0d: got req=%b we=%b %h %h %b rv=%b want 1 1 000200 deadbeef 0011 0", c, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.d_rvalid);
      end
      if (c == 2) bus.mem_ready = 1'b1;
      tick();
    end
    tests_run++; if ({bus.d_rvalid, bus.d_rdata, bus.err, bus.mem_req} !== {1'b1, model_d_rdata, 2'b00}) begin fails++; $display("FAIL store_done: got %b/%h err=%b req=%b want 1/%h/0/0", bus.d_rvalid, bus.d_rdata, bus.err, bus.mem_req, model_d_rdata); end
    bus.mem_ready = 1'b0;
    tick();
    tests_run++; if ({bus.d_rvalid, bus.mem_req, bus.mem_addr} !== {2'b00, 24'h000200}) begin fails++; $display("FAIL store_idle: got rv=%b req=%b addr=%h want 0 0 000200", bus.d_rvalid, bus.mem_req, bus.mem_addr); end
    model_last_d = 1'b1; model_wdata = 32'hDEADBEEF; model_addr = 24'h000200;
    bus.d_we = 1'b0;
  endtask

  task automatic test_timeout();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 24'h000500; bus.mem_rdata = 32'hFFFFFFFF;
    tick();
    bus.d_req = 1'b0;
    for (int c = 1; c < TO; c++) begin
      tick();
      tests_run++; if ({bus.d_rvalid, bus.err, bus.mem_req, bus.busy} !== 4'b0011) begin fails++; $display("FAIL timeout_wait_c%0d: got rv/err/req/busy=%b want 0011", c, {bus.d_rvalid, bus.err, bus.mem_req, bus.busy}); end
    end
    tick();
    tests_run++; if ({bus.d_rvalid, bus.err, bus.d_rdata, bus.busy, bus.mem_req} !== {2'b11, 32'h0, 2'b00}) begin fails++; $display("FAIL timeout_abort: got rv=%b err=%b %h busy=%b req=%b want 1 1 00000000 0 0", bus.d_rvalid, bus.err, bus.d_rdata, bus.busy, bus.mem_req); end
    tick();
    tests_run++; if ({bus.err, bus.d_rvalid, bus.busy} !== 3'b000) begin fails++; $display("FAIL timeout_pulse: got err/rv/busy=%b want 000", {bus.err, bus.d_rvalid, bus.busy}); end
    bus.d_req = 1'b1; bus.d_addr = 24'h000504;
    tick();
    bus.d_req = 1'b0;
    repeat (TO - 1) tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    tick();
    tests_run++; if ({bus.d_rvalid, bus.err, bus.d_rdata} !== {2'b10, 32'hCAFEF00D}) begin fails++; $display("FAIL timeout_race: got rv=%b err=%b %h want 1 0 cafef00d", bus.d_rvalid, bus.err, bus.d_rdata); end
    bus.mem_ready = 1'b0;
    model_last_d = 1'b1; model_d_rdata = 32'hCAFEF00D; model_addr = 24'h000504;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic ir, dr, dwe, win_d, ok, done;
      logic [AW-1:0] ia, da;
      logic [31:0] wd, rd;
      logic [3:0] ws;
      int k;
      ir = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) ir = 1'b1;
      ia = AW'($urandom); da = AW'($urandom); dwe = 1'($urandom_range(0, 1));
      wd = $urandom; ws = 4'($urandom); rd = '0;
      k = $urandom_range(1, TO + 2);
      if ($urandom_range(0, 3) == 0) begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        tick();
        tests_run++; if ({bus.mem_req, bus.busy, bus.mem_addr} !== {2'b00, model_addr}) begin fails++; $display("FAIL rnd%0d_idle: got req=%b busy=%b addr=%h want 0 0 %h", n, bus.mem_req, bus.busy, bus.mem_addr, model_addr); end
        bus.mem_ready = 1'b0;
      end
      bus.i_req = ir; bus.i_addr = ia;
      bus.d_req = dr; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = wd; bus.d_wstrb = ws;
      if (ir && dr) win_d = !model_last_d;
      else          win_d = dr;
      tick();
      model_addr = win_d ? da : ia;
      if (win_d) model_wdata = wd;
      tests_run++; if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid} !== {!win_d, win_d, 2'b00}) begin fails++; $display("FAIL rnd%0d_gnt: got gi/gd/rvi/rvd=%b want %b", n, {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid}, {!win_d, win_d, 2'b00}); end
      tests_run++;
      if ({bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wstrb, bus.mem_wdata} !== {1'b1, model_addr, win_d & dwe, win_d ? ws : 4'b0000, model_wdata}) begin
        fails++; $display("FAIL rnd%0d_bus: got req=%b %h we=%b %b %h want 1 %h %b %b %h", n, bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wstrb, bus.mem_wdata, model_addr, win_d & dwe, win_d ? ws : 4'b0000, model_wdata);
      end
      model_last_d = win_d;
      done = 1'b0;
      for (int c = 1; c <= TO && !done; c++) begin
        rd = $urandom;
        bus.mem_ready = (c == k); bus.mem_rdata = rd;
        bus.i_req = 1'($urandom_range(0, 1)); bus.d_req = 1'($urandom_range(0, 1));
        tick();
        if (c == k || c == TO) done = 1'b1;
        else begin
          tests_run++; if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.err, bus.mem_req} !== 6'b000001) begin fails++; $display("FAIL rnd%0d_busy_c%0d: got %b want 000001", n, c, {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.err, bus.mem_req}); end
        end
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_ready = 1'b0;
      ok = (k <= TO);
      if (win_d) model_d_rdata = !ok ? 32'h0 : (dwe ? model_d_rdata : rd);
      else       model_i_rdata = !ok ? 32'h0 : rd;
      tests_run++;
      if ({bus.i_rvalid, bus.d_rvalid, bus.err, bus.busy, bus.mem_req, bus.i_rdata, bus.d_rdata} !== {!win_d, win_d, !ok, 2'b00, model_i_rdata, model_d_rdata}) begin
        fails++; $display("FAIL rnd%0d_done: got rvi=%b rvd=%b err=%b busy=%b req=%b %h %h want %b %b %b 0 0 %h %h", n, bus.i_rvalid, bus.d_rvalid, bus.err, bus.busy, bus.mem_req, bus.i_rdata, bus.d_rdata, !win_d, win_d, !ok, model_i_rdata, model_d_rdata);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    clear_inputs();
    bus.d_req = 1'b1; bus.d_addr = 24'h000600;
    tick();
    tests_run++; if (bus.d_gnt !== 1'b1) begin fails++; $display("FAIL midrst_gnt: got %b want 1", bus.d_gnt); end
    bus.d_req = 1'b0;
    repeat (2) tick();
    #2 resetn = 1'b1;
    #1;
    tests_run++; if (all_outs() !== '0) begin fails++; $display("FAIL midrst_outputs: got %h want 0", all_outs()); end
    @(negedge clk) resetn = 1'b0;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h12345678;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++; if ({bus.i_rvalid, bus.d_rvalid, bus.err, bus.mem_req} !== 4'b0000) begin fails++; $display("FAIL midrst_quiet_c%0d: got rvi/rvd/err/req=%b want 0000", c, {bus.i_rvalid, bus.d_rvalid, bus.err, bus.mem_req}); end
    end
    bus.mem_ready = 1'b0; bus.i_req = 1'b1; bus.i_addr = 24'h000700; bus.d_req = 1'b1;
    tick();
    tests_run++; if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin fails++; $display("FAIL midrst_tie: got i/d=%b want 01", {bus.i_gnt, bus.d_gnt}); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_tie_alternation();
    test_single_fetch();
    test_store();
    test_timeout();
    test_random();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
